sram_controller: RTL and testbench

- Sits directly downstream of the MEM stage; replaces the single-cycle on-chip data memory with off-chip 16-bit SRAM behind a multi-cycle access FSM.
- Splits each 32-bit load/store into two halfword accesses, low half first.
- Drops `ready` while busy so the hazard/freeze logic can stall the whole pipeline.
- Uses the same data address map as the processor: byte address 1024 and up is data space.

---
 rtl/sram_pkg.sv | 20 ++
 rtl/access_timer.sv | 27 ++
 rtl/sram_controller.sv | 131 +++++++++++++
 tb/tb_sram_controller.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and address helpers for the off-chip SRAM data-memory controller.
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int          SRAM_AW_DEF   = 18;
    localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;

    // Byte address in data space -> halfword index; caller truncates to the SRAM width.
    function automatic logic [31:0] hw_index(input logic [31:0] byte_addr,
                                             input logic [31:0] base);
        return (byte_addr - base) >> 1;
    endfunction

endpackage

// File: rtl/access_timer.sv
// Per-halfword access timer: counts held cycles and flags the final one.
module access_timer #(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    output logic last
);

    localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

    logic [3:0] count;

    assign last = en && (count == LAST_CNT);

    // Wrapping on 'last' lets the HI phase start from zero right after LO.
    always_ff @(posedge clk) begin
        if (rst || clear || last) begin
            count <= '0;
        end else if (en) begin
            count <= count + 4'd1;
        end
    end

endmodule

// File: rtl/sram_controller.sv
// Multi-cycle 16-bit SRAM controller: each 32-bit load/store becomes two halfword
// accesses (low first) while ready is held low to freeze the pipeline.
module sram_controller
    import sram_pkg::*;
#(
    parameter int          ACCESS_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR     = BASE_ADDR_DEF,
    parameter int          SRAM_AW       = SRAM_AW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    localparam bit SINGLE_CYCLE = (ACCESS_CYCLES == 1);

    state_t             state, state_nx;
    logic               req;
    logic               op_write;
    logic               in_access;
    logic               timer_clear;
    logic               last;
    logic               write_we_n;
    logic [SRAM_AW-1:0] hw_lo, hw_hi;

    assign req         = rd_en | wr_en;
    assign in_access   = (state == LO) || (state == HI);
    assign timer_clear = (state == IDLE);
    assign hw_lo       = SRAM_AW'(hw_index(address, BASE_ADDR));
    assign hw_hi       = hw_lo + SRAM_AW'(1);

    // The last cycle of each halfword deasserts we_n to give data hold time,
    // unless there is only one cycle to spend.
    assign write_we_n  = SINGLE_CYCLE ? 1'b0 : last;

    access_timer #(
        .ACCESS_CYCLES(ACCESS_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .en    (in_access),
        .clear (timer_clear),
        .last  (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Write wins when both requests are raised together.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_write <= 1'b0;
        end else if ((state == IDLE) && req) begin
            op_write <= wr_en;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            read_data <= '0;
        end else if (!op_write && last) begin
            if (state == LO) begin
                read_data[15:0] <= sram_dq_in;
            end else if (state == HI) begin
                read_data[31:16] <= sram_dq_in;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req)  state_nx = LO;
            LO:      if (last) state_nx = HI;
            HI:      if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ready       = 1'b0;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        case (state)
            IDLE: begin
                ready = ~req;
            end
            LO: begin
                sram_addr = hw_lo;
                if (op_write) begin
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = write_data[15:0];
                    sram_we_n   = write_we_n;
                end
            end
            HI: begin
                sram_addr = hw_hi;
                if (op_write) begin
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = write_data[31:16];
                    sram_we_n   = write_we_n;
                end
            end
            DONE: begin
                ready = 1'b1;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: transaction-level model plus per-cycle bus checks,
// one default build and one single-cycle-access build.
module tb_sram_controller;

    localparam int          AC      = 2;
    localparam logic [31:0] BASE    = 32'd1024;
    localparam logic [31:0] AW_MASK = 32'h3FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rd_en, wr_en;
    logic [31:0] address, write_data, read_data;
    logic        ready, sram_dq_oe, sram_we_n;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;

    logic        rd1, wr1;
    logic [31:0] addr1, wd1, read_data1;
    logic        ready1, sram_dq_oe1, sram_we_n1;
    logic [17:0] sram_addr1;
    logic [15:0] sram_dq_out1, sram_dq_in1;

    sram_controller #(.ACCESS_CYCLES(AC)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
        .write_data(write_data), .read_data(read_data), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
        .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
    );

    sram_controller #(.ACCESS_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .rd_en(rd1), .wr_en(wr1), .address(addr1),
        .write_data(wd1), .read_data(read_data1), .ready(ready1),
        .sram_addr(sram_addr1), .sram_dq_out(sram_dq_out1), .sram_dq_in(sram_dq_in1),
        .sram_dq_oe(sram_dq_oe1), .sram_we_n(sram_we_n1)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Asynchronous SRAM model for the default build: a halfword is stored when
    // we_n rises while the controller still drives the same address and data.
    logic [15:0] mem [0:255];
    int          mem_writes = 0;
    logic        p_we_n, p_oe;
    logic [17:0] p_addr;

    assign sram_dq_in  = mem[sram_addr[7:0]];
    assign sram_dq_in1 = {sram_addr1[7:0], 8'h5A};

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
        p_we_n = 1'b1;
        p_oe   = 1'b0;
        p_addr = '0;
        forever begin
            @(negedge clk);
            if (!p_we_n && p_oe && sram_we_n && sram_dq_oe && (sram_addr == p_addr)) begin
                mem[sram_addr[7:0]] = sram_dq_out;
                mem_writes++;
            end
            p_we_n = sram_we_n;
            p_oe   = sram_dq_oe;
            p_addr = sram_addr;
        end
    end

    // Transaction model state, written by the driver and read by the checker.
    logic [15:0] ref_mem [0:255];
    logic        chk_en = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_write;
    logic [31:0] m_hw, m_wd;
    logic [31:0] m_rdata = '0;
    int          m_start;

    logic        rdy_tr [0:15];
    logic        we_tr  [0:15];
    logic        oe_tr  [0:15];
    logic [17:0] addr_tr[0:15];

    int          ck, sub;
    logic        half;
    logic [31:0] e_addr, h1;

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && !m_busy) begin
                check("idle_ready", ready, 1'b1);
                check("idle_oe", sram_dq_oe, 1'b0);
                check("idle_we_n", sram_we_n, 1'b1);
                check("idle_addr", sram_addr, 0);
                check("idle_rdata", read_data, m_rdata);
            end else if (chk_en) begin
                ck = cyc - m_start;
                if (ck < 16) begin
                    rdy_tr[ck] = ready; we_tr[ck] = sram_we_n;
                    oe_tr[ck] = sram_dq_oe; addr_tr[ck] = sram_addr;
                end
                if (ck == 0) begin
                    check("req_ready", ready, 1'b0);
                end else if (ck <= 2 * AC) begin
                    half   = (ck > AC);
                    sub    = half ? ck - AC - 1 : ck - 1;
                    e_addr = (m_hw + (half ? 32'd1 : 32'd0)) & AW_MASK;
                    check("busy_ready", ready, 1'b0);
                    check("busy_addr", sram_addr, e_addr);
                    if (m_write) begin
                        check("wr_oe", sram_dq_oe, 1'b1);
                        check("wr_dq", sram_dq_out, half ? m_wd[31:16] : m_wd[15:0]);
                        check("wr_we_n", sram_we_n, (sub == AC - 1) ? 1'b1 : 1'b0);
                        check("wr_rdata", read_data, m_rdata);
                    end else begin
                        check("rd_oe", sram_dq_oe, 1'b0);
                        check("rd_we_n", sram_we_n, 1'b1);
                    end
                end else begin
                    check("done_ready", ready, 1'b1);
                    check("done_oe", sram_dq_oe, 1'b0);
                    check("done_we_n", sram_we_n, 1'b1);
                    if (!m_write) begin
                        h1 = (m_hw + 32'd1) & AW_MASK;
                        m_rdata = {ref_mem[h1[7:0]], ref_mem[m_hw[7:0]]};
                    end
                    check("done_rdata", read_data, m_rdata);
                end
            end
        end
    end

    task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd);
        logic [31:0] hw1;
        @(posedge clk); #1;
        rd_en = rd; wr_en = wr; address = a; write_data = wd;
        m_write = wr;
        m_wd    = wd;
        m_hw    = ((a - BASE) >> 1) & AW_MASK;
        m_start = cyc;
        m_busy  = 1'b1;
        if (wr) begin
            hw1 = (m_hw + 32'd1) & AW_MASK;
            ref_mem[m_hw[7:0]] = wd[15:0];
            ref_mem[hw1[7:0]]  = wd[31:16];
        end
        repeat (2 * AC + 2) @(posedge clk);
        #1;
        rd_en = 1'b0; wr_en = 1'b0; m_busy = 1'b0;
    endtask

    int pulses;

    initial begin
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
        rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wd1 = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'hA000 + 16'(i);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", ready, 1'b1);
        check("rst_we_n", sram_we_n, 1'b1);
        check("rst_oe", sram_dq_oe, 1'b0);
        check("rst_addr", sram_addr, 0);
        check("rst_dq_out", sram_dq_out, 0);
        check("rst_rdata", read_data, 0);

        // Abort a write with reset during its first LO cycle.
        @(posedge clk); #1;
        rst = 1'b0; wr_en = 1'b1; address = 32'd1024; write_data = 32'h11112222;
        @(posedge clk); #1;
        rst = 1'b1; wr_en = 1'b0;
        @(negedge clk);
        check("abort_lo_we_n", sram_we_n, 1'b0);
        check("abort_lo_ready", ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_we_n", sram_we_n, 1'b1);
        check("abort_oe", sram_dq_oe, 1'b0);
        check("abort_ready", ready, 1'b1);
        check("abort_no_write", mem_writes, 0);
        check("abort_mem0", mem[0], 16'hA000);

        chk_en = 1'b1;

        issue(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
        check("st_mem0", mem[0], 16'hBEEF);
        check("st_mem1", mem[1], 16'hDEAD);
        check("st_we_pattern", {we_tr[1], we_tr[2], we_tr[3], we_tr[4]}, 4'b0101);
        check("st_ready_wave", {rdy_tr[0], rdy_tr[1], rdy_tr[2], rdy_tr[3], rdy_tr[4], rdy_tr[5]}, 6'b000001);

        issue(1'b1, 1'b0, 32'd1024, 32'h0);
        check("ld_word", read_data, 32'hDEADBEEF);
        check("ld_ready_wave", {rdy_tr[0], rdy_tr[1], rdy_tr[2], rdy_tr[3], rdy_tr[4], rdy_tr[5]}, 6'b000001);

        issue(1'b0, 1'b1, 32'd1032, 32'h12345678);
        check("xl_lo_addr", addr_tr[1], 18'd4);
        check("xl_hi_addr", addr_tr[3], 18'd5);
        check("xl_mem4", mem[4], 16'h5678);

        issue(1'b1, 1'b0, 32'd1028, 32'h0);
        check("xl_prior", read_data, 32'hA003A002);

        issue(1'b1, 1'b1, 32'd1040, 32'h0BADF00D);
        check("both_oe", oe_tr[1], 1'b1);
        check("both_mem8", mem[8], 16'hF00D);
        check("both_rdata", read_data, 32'hA003A002);

        issue(1'b1, 1'b0, 32'd1020, 32'h0);
        check("wrap_lo_addr", addr_tr[1], 18'h3FFFE);
        check("wrap_hi_addr", addr_tr[3], 18'h3FFFF);
        check("wrap_rdata", read_data, 32'hA0FFA0FE);

        // Single-cycle build: load of 1032 (halfwords 4 and 5).
        @(posedge clk); #1;
        rd1 = 1'b1; addr1 = 32'd1032;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("ac1_ready", ready1, (k == 3) ? 1'b1 : 1'b0);
            if (k == 1) check("ac1_lo_addr", sram_addr1, 18'd4);
            if (k == 2) check("ac1_hi_addr", sram_addr1, 18'd5);
        end
        check("ac1_rdata", read_data1, 32'h055A045A);
        @(posedge clk); #1;
        rd1 = 1'b0;

        // Single-cycle build: back-to-back load then store with the request held.
        @(posedge clk); #1;
        rd1 = 1'b1; addr1 = 32'd1024;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("b2b_ready", ready1, (k == 3 || k == 7) ? 1'b1 : 1'b0);
            if (k == 5 || k == 6) begin
                check("b2b_we_n", sram_we_n1, 1'b0);
                check("b2b_oe", sram_dq_oe1, 1'b1);
                check("b2b_addr", sram_addr1, (k == 5) ? 18'd8 : 18'd9);
                check("b2b_dq", sram_dq_out1, (k == 5) ? 16'hF00D : 16'hCAFE);
            end
            if (ready1) begin
                pulses++;
                check("b2b_rdata", read_data1, 32'h015A005A);
            end
            if (ready1 && k == 3) begin
                @(posedge clk); #1;
                rd1 = 1'b0; wr1 = 1'b1; addr1 = 32'd1040; wd1 = 32'hCAFEF00D;
            end
        end
        check("b2b_pulses", pulses, 2);
        @(posedge clk); #1;
        wr1 = 1'b0;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
